// File: rtl/dataflow_pkg.sv
// dataflow_pkg: pipeline stage names shared across the core
package dataflow_pkg;
  typedef enum logic [1:0] {Decode = 2'd0, Execute = 2'd1, Memory = 2'd2, WriteBack = 2'd3} stages_t;
endpackage

// File: rtl/forwarding_unit_pkg.sv
// forwarding_unit_pkg: operand classification and bypass-source encodings for the forwarding unit
package forwarding_unit_pkg;
  typedef enum logic [1:0] {NoType = 2'd0, Type1 = 2'd1, Type2 = 2'd2, Type1_3 = 2'd3} forwarding_type_t;
  typedef enum logic [1:0] {NoForwarding = 2'd0, ForwardFromEx = 2'd1, ForwardFromMem = 2'd2, ForwardFromWb = 2'd3} forwarding_t;
endpackage

// File: rtl/forwarding_select.sv
// forwarding_select: nearest-stage bypass choice for one source operand
module forwarding_select
  import forwarding_unit_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rd_mem,
  input  logic [4:0] rd_wb,
  input  logic       en_ex,
  input  logic       en_mem,
  input  logic       en_wb,
  output logic [1:0] sel
);
  logic hit_ex, hit_mem, hit_wb;
  // x0 is hard-wired zero, so a zero source never takes a bypass
  assign hit_ex  = en_ex  && (rs == rd_ex)  && (rd_ex  != 5'd0);
  assign hit_mem = en_mem && (rs == rd_mem) && (rd_mem != 5'd0);
  assign hit_wb  = en_wb  && (rs == rd_wb)  && (rd_wb  != 5'd0);
  always_comb
    sel = hit_ex  ? ForwardFromEx  :
          hit_mem ? ForwardFromMem :
          hit_wb  ? ForwardFromWb  : NoForwarding;
endmodule

// File: rtl/forwarding_unit.sv
// forwarding_unit: per-operand bypass selection for ID, EX and MEM sources (purely combinational)
module forwarding_unit
  import forwarding_unit_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] forwarding_type_id,
  input  logic [1:0] forwarding_type_ex,
  input  logic [1:0] forwarding_type_mem,
  input  logic       reg_we_mem,
  input  logic       reg_we_wb,
  input  logic       zicsr_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rd_mem,
  input  logic [4:0] rd_wb,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic [4:0] rs1_ex,
  input  logic [4:0] rs2_ex,
  input  logic [4:0] rs2_mem,
  output logic [1:0] forward_rs1_id,
  output logic [1:0] forward_rs2_id,
  output logic [1:0] forward_rs1_ex,
  output logic [1:0] forward_rs2_ex,
  output logic [1:0] forward_rs2_mem
);
  logic unused_clk_rst;
  logic id_ex, id_mem, id_wb, ex_mem, ex_wb, mem_wb, ex_typed;
  assign unused_clk_rst = ^{clock, reset_n};
  // Only Zicsr results exist early enough in EX to feed the ID stage
  assign id_ex    = zicsr_ex && (forwarding_type_id == Type2);
  assign id_mem   = reg_we_mem && (forwarding_type_id == Type2);
  assign id_wb    = reg_we_wb && (forwarding_type_id != NoType);
  assign ex_typed = (forwarding_type_ex == Type1) || (forwarding_type_ex == Type1_3);
  assign ex_mem   = reg_we_mem && ex_typed;
  assign ex_wb    = reg_we_wb && ex_typed;
  assign mem_wb   = reg_we_wb && (forwarding_type_mem == Type1_3);
  forwarding_select u_rs1_id (.rs(rs1_id), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .en_ex(id_ex), .en_mem(id_mem), .en_wb(id_wb), .sel(forward_rs1_id));
  forwarding_select u_rs2_id (.rs(rs2_id), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .en_ex(1'b0), .en_mem(id_mem), .en_wb(id_wb), .sel(forward_rs2_id));
  forwarding_select u_rs1_ex (.rs(rs1_ex), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .en_ex(1'b0), .en_mem(ex_mem), .en_wb(ex_wb), .sel(forward_rs1_ex));
  forwarding_select u_rs2_ex (.rs(rs2_ex), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .en_ex(1'b0), .en_mem(ex_mem), .en_wb(ex_wb), .sel(forward_rs2_ex));
  forwarding_select u_rs2_mem (.rs(rs2_mem), .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .en_ex(1'b0), .en_mem(1'b0), .en_wb(mem_wb), .sel(forward_rs2_mem));
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: directed cases plus randomized comparison against a rule-table model
module tb_forwarding_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] ft_id, ft_ex, ft_mem;
  logic we_mem, we_wb, zicsr;
  logic [4:0] rd_ex, rd_mem, rd_wb, rs1_id, rs2_id, rs1_ex, rs2_ex, rs2_mem;
  logic [1:0] f1id, f2id, f1ex, f2ex, f2mem;
  int errs = 0;
  int checks = 0;
  // allowed sources per type, bit2=EX bit1=MEM bit0=WB
  logic [2:0] id_m [4] = '{3'b000, 3'b001, 3'b111, 3'b001};
  logic [2:0] ex_m [4] = '{3'b000, 3'b011, 3'b000, 3'b011};
  logic [2:0] mem_m[4] = '{3'b000, 3'b000, 3'b000, 3'b001};

  always #5 clock = ~clock;

  forwarding_unit dut (
    .clock(clock), .reset_n(reset_n),
    .forwarding_type_id(ft_id), .forwarding_type_ex(ft_ex), .forwarding_type_mem(ft_mem),
    .reg_we_mem(we_mem), .reg_we_wb(we_wb), .zicsr_ex(zicsr),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rs2_mem(rs2_mem),
    .forward_rs1_id(f1id), .forward_rs2_id(f2id), .forward_rs1_ex(f1ex),
    .forward_rs2_ex(f2ex), .forward_rs2_mem(f2mem)
  );

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [4:0] rs, input logic [2:0] allow);
    if (rs == 5'd0) return 2'd0;
    if (allow[2] && zicsr && rs == rd_ex) return 2'd1;
    if (allow[1] && we_mem && rs == rd_mem) return 2'd2;
    if (allow[0] && we_wb && rs == rd_wb) return 2'd3;
    return 2'd0;
  endfunction

  task automatic clear();
    {ft_id, ft_ex, ft_mem, we_mem, we_wb, zicsr} = '0;
    {rd_ex, rd_mem, rd_wb, rs1_id, rs2_id, rs1_ex, rs2_ex, rs2_mem} = '0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] e1id, e2id, e1ex, e2ex, e2mem);
    #1;
    check({tag, "_rs1_id"}, f1id, e1id);
    check({tag, "_rs2_id"}, f2id, e2id);
    check({tag, "_rs1_ex"}, f1ex, e1ex);
    check({tag, "_rs2_ex"}, f2ex, e2ex);
    check({tag, "_rs2_mem"}, f2mem, e2mem);
  endtask

  initial begin
    clear();
    check_all("reset", 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    clear(); ft_id = 2; rs1_id = 5; rs2_id = 5; rd_ex = 5; zicsr = 1; rd_mem = 5; we_mem = 1;
    #1; check("t1_rs1_ex_prio", f1id, 2'd1); check("t1_rs2_mem", f2id, 2'd2);
    clear(); ft_id = 1; rs1_id = 7; rd_mem = 7; we_mem = 1; rd_wb = 7; we_wb = 1;
    #1; check("t2_rs1_wb", f1id, 2'd3);
    clear(); ft_ex = 3; rs2_ex = 3; rd_ex = 3; zicsr = 1; rd_mem = 3; we_mem = 1;
    #1; check("t3_rs2ex_mem", f2ex, 2'd2);
    we_mem = 0; rd_wb = 3; we_wb = 1;
    #1; check("t3_rs2ex_wb", f2ex, 2'd3);
    clear(); ft_mem = 3; rs2_mem = 9; rd_wb = 9; we_wb = 1;
    #1; check("t4_mem_wb", f2mem, 2'd3);
    ft_mem = 1;
    #1; check("t4_mem_type1", f2mem, 2'd0);
    clear(); we_mem = 1; we_wb = 1; zicsr = 1; ft_id = 2; ft_ex = 3; ft_mem = 3;
    check_all("t5_x0", 0, 0, 0, 0, 0);
    {rd_ex, rd_mem, rd_wb, rs1_id, rs2_id, rs1_ex, rs2_ex, rs2_mem} = {8{5'd4}};
    ft_id = 0; ft_ex = 0; ft_mem = 0;
    check_all("t6_notype", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10000; i++) begin
      reset_n = 1'($urandom);
      {ft_id, ft_ex, ft_mem} = 6'($urandom);
      {we_mem, we_wb, zicsr} = 3'($urandom);
      rd_ex = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3));
      rd_wb = 5'($urandom_range(0, 3)); rs1_id = 5'($urandom_range(0, 3));
      rs2_id = 5'($urandom_range(0, 3)); rs1_ex = 5'($urandom_range(0, 3));
      rs2_ex = 5'($urandom_range(0, 3)); rs2_mem = 5'($urandom_range(0, 3));
      if (i % 8 == 0) rs1_id = 5'($urandom);
      check_all("rnd", pick(rs1_id, id_m[ft_id]), pick(rs2_id, id_m[ft_id] & 3'b011),
        pick(rs1_ex, ex_m[ft_ex]), pick(rs2_ex, ex_m[ft_ex]), pick(rs2_mem, mem_m[ft_mem]));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
